regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Sequences all accesses to the 32x32 three-port register file (two combinational read ports, one clocked write port, r0 hardwired to zero).
- Arbitrates the single write port between two writeback requesters: A (ALU) and B (load unit). Uses round-robin and registers the winning write into we3/wa3/wd3.
- Keeps a per-register busy scoreboard and stalls instruction issue on RAW/WAW hazards against in-flight writes.

Parameters:
- DW, 32, data width of wd3 / writeback data.
- AW, 5, register address width; scoreboard has 2**AW entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode stage presents an instruction.
- issue_ra1  in  AW  source register 1.
- issue_ra2  in  AW  source register 2.
- issue_wa  in  AW  destination register (0 = no destination).
- issue_ready  out  1  issue accepted this cycle (combinational).
- a_valid  in  1  requester A write request.
- a_wa  in  AW  requester A write address.
- a_wd  in  DW  requester A write data.
- a_ready  out  1  A granted this cycle (combinational).
- b_valid  in  1  requester B write request.
- b_wa  in  AW  requester B write address.
- b_wd  in  DW  requester B write data.
- b_ready  out  1  B granted this cycle (combinational).
- we3  out  1  register-file write enable (registered).
- wa3  out  AW  register-file write address (registered).
- wd3  out  DW  register-file write data (registered).
- busy  out  2**AW  scoreboard; bit i = write to ri pending.
- err_stray  out  1  sticky flag: a writeback targeted a non-busy nonzero register.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - we3=0, wa3=0, wd3=0.
  - busy=0, err_stray=0.
  - Round-robin pointer = A. Any pending write is discarded.
- Arbitration (combinational):
  - Only one of A or B is valid: that one is granted.
  - Both valid: grant the requester the pointer selects, then move the pointer to the other requester on that edge.
  - Pointer changes only on a contended grant.
  - a_ready / b_ready are never both high.
- A handshake is valid & ready at a rising edge.
- Write stage: a handshake in cycle N drives we3=1, wa3=wa, wd3=wd for exactly cycle N+1, so the register file writes at the end of N+1. Latency is one cycle.
  - No handshake: we3=0 next cycle; wa3/wd3 hold their previous values.
  - wa=0: the handshake is accepted but we3 stays 0.
- Throughput: one write per cycle, back-to-back, no bubbles.
- Scoreboard:
  - Set: at an edge with issue_valid & issue_ready & issue_wa!=0, busy[issue_wa] <= 1.
  - Clear: at an edge with we3=1, busy[wa3] <= 0. Clear happens on the same edge the regfile commits.
  - Set and clear of the same register on the same edge: set wins.
  - busy[0] is always 0.
- Issue stall: issue_ready = issue_valid AND NOT any of the following:
  - (ra1!=0 & busy[ra1])
  - (ra2!=0 & busy[ra2])
  - (wa!=0 & busy[wa])
  - Stall condition uses the current busy value, with no same-cycle bypass of a clearing write.
- err_stray: set at the handshake edge if the granted wa!=0 and busy[wa]=0 and no same-edge set of that register. Clears only on reset.

Test Plan:
- Reset during write: assert reset while we3=1 -> we3, busy, err_stray and wd3 go to 0 immediately, without waiting for clk.
- Single write:
  - Issue wa=5 -> busy[5]=1.
  - a_valid, a_wa=5, a_wd=32'hDEADBEEF in cycle N -> a_ready=1 in N; we3=1, wa3=5, wd3=DEADBEEF in N+1 only; busy[5]=0 after the N+1 edge.
- Round-robin:
  - Issue wa=3 and wa=4.
  - Hold a_valid (wa=3) and b_valid (wa=4) together -> A granted first, then B next cycle.
  - Second contention burst -> B granted first.
  - we3 high for 2 consecutive cycles in each burst.
- Hazard stall:
  - busy[7]=1; issue ra1=7 -> issue_ready=0.
  - issue_ready goes to 1 in the cycle after the we3 edge for r7.
  - ra1=0 with busy irrelevant -> never stalls.
- Set/clear collision: we3=1, wa3=9 on the same edge as an issue with wa=9 -> busy[9] remains 1.
- Stray and r0 writes:
  - b write to non-busy r12 -> err_stray=1 and stays set.
  - Write to wa=0 -> handshake completes, we3 stays 0, err_stray unchanged.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler for the 32x32 register file.
// Round-robin arbitration of two writeback sources, a registered write stage, and a busy scoreboard that stalls hazardous issue.
module regfile_wb_scheduler #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_ra1,
    input  logic [AW-1:0]        issue_ra2,
    input  logic [AW-1:0]        issue_wa,
    output logic                 issue_ready,
    input  logic                 a_valid,
    input  logic [AW-1:0]        a_wa,
    input  logic [DW-1:0]        a_wd,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [AW-1:0]        b_wa,
    input  logic [DW-1:0]        b_wd,
    output logic                 b_ready,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [DW-1:0]        wd3,
    output logic [(2**AW)-1:0]   busy,
    output logic                 err_stray
);

    localparam int unsigned NREG = 2**AW;

    logic            rr_b;
    logic            grant_a;
    logic            grant_b;
    logic            win_valid;
    logic [AW-1:0]   win_wa;
    logic [DW-1:0]   win_wd;
    logic            hazard;
    logic            issue_set;
    logic            stray;
    logic [NREG-1:0] busy_nxt;

    // rr_b selects B on contention; it only moves when both sources request
    always_comb begin
        grant_a   = a_valid & (~b_valid | ~rr_b);
        grant_b   = b_valid & (~a_valid | rr_b);
        win_valid = grant_a | grant_b;
        win_wa    = grant_a ? a_wa : b_wa;
        win_wd    = grant_a ? a_wd : b_wd;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Stall uses the registered scoreboard only; a write committing this cycle is not bypassed
    always_comb begin
        hazard = ((issue_ra1 != '0) & busy[issue_ra1])
               | ((issue_ra2 != '0) & busy[issue_ra2])
               | ((issue_wa  != '0) & busy[issue_wa]);
        issue_ready = issue_valid & ~hazard;
        issue_set   = issue_ready & (issue_wa != '0);
        stray = win_valid & (win_wa != '0) & ~busy[win_wa]
              & ~(issue_set & (issue_wa == win_wa));
    end

    // Clear on commit, then set from issue so a same-edge set wins
    always_comb begin
        busy_nxt = busy;
        if (we3) begin
            busy_nxt[wa3] = 1'b0;
        end
        if (issue_set) begin
            busy_nxt[issue_wa] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_b      <= 1'b0;
            we3       <= 1'b0;
            wa3       <= '0;
            wd3       <= '0;
            busy      <= '0;
            err_stray <= 1'b0;
        end else begin
            we3  <= win_valid & (win_wa != '0);
            busy <= busy_nxt;
            if (win_valid) begin
                wa3 <= win_wa;
                wd3 <= win_wd;
            end
            if (a_valid & b_valid) begin
                rr_b <= ~rr_b;
            end
            if (stray) begin
                err_stray <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected writes are queued at stimulus time
// and a negedge monitor pops and compares them against every we3 cycle.
module tb_regfile_wb_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic [AW-1:0]     issue_ra1;
    logic [AW-1:0]     issue_ra2;
    logic [AW-1:0]     issue_wa;
    logic              issue_ready;
    logic              a_valid;
    logic [AW-1:0]     a_wa;
    logic [DW-1:0]     a_wd;
    logic              a_ready;
    logic              b_valid;
    logic [AW-1:0]     b_wa;
    logic [DW-1:0]     b_wd;
    logic              b_ready;
    logic              we3;
    logic [AW-1:0]     wa3;
    logic [DW-1:0]     wd3;
    logic [31:0]       busy;
    logic              err_stray;

    int n_checks = 0;
    int n_fail   = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    regfile_wb_scheduler #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ra1(issue_ra1), .issue_ra2(issue_ra2),
        .issue_wa(issue_wa), .issue_ready(issue_ready),
        .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_ready(a_ready),
        .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .err_stray(err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every we3 cycle must match the oldest queued write
    always @(negedge clk) begin
        if (!reset && we3) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we3", 64'(wa3), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wa3", 64'(wa3), 64'(mon_e.wa));
                chk("wd3", 64'(wd3), 64'(mon_e.wd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wr_t e;
        e.wa = wa;
        e.wd = wd;
        if (wa != '0) exp_q.push_back(e);
    endtask

    task automatic do_issue(input logic [AW-1:0] wa);
        issue_valid = 1'b1;
        issue_ra1   = '0;
        issue_ra2   = '0;
        issue_wa    = wa;
        @(negedge clk);
        chk("issue_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0;
        issue_wa    = '0;
        chk("busy_set", 64'(busy[wa]), 64'd1);
    endtask

    task automatic single_write(input bit sel_b, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (sel_b) begin
            b_valid = 1'b1; b_wa = wa; b_wd = wd;
        end else begin
            a_valid = 1'b1; a_wa = wa; a_wd = wd;
        end
        @(negedge clk);
        chk("a_ready_single", 64'(a_ready), sel_b ? 64'd0 : 64'd1);
        chk("b_ready_single", 64'(b_ready), sel_b ? 64'd1 : 64'd0);
        push(wa, wd);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_ra1 = '0; issue_ra2 = '0; issue_wa = '0;
        a_valid = 1'b0; a_wa = '0; a_wd = '0;
        b_valid = 1'b0; b_wa = '0; b_wd = '0;
        #2;
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_wa3", 64'(wa3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_stray), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single write to r5
        do_issue(5'd5);
        single_write(1'b0, 5'd5, 32'hDEADBEEF);
        chk("we3_n1", 64'(we3), 64'd1);
        chk("busy5_before_commit", 64'(busy[5]), 64'd1);
        tick();
        chk("busy5_cleared", 64'(busy[5]), 64'd0);
        chk("we3_n2", 64'(we3), 64'd0);

        // Write to r0: handshake but no commit, no stray
        single_write(1'b0, 5'd0, 32'h1234);
        @(negedge clk);
        chk("we3_r0", 64'(we3), 64'd0);
        chk("err_r0", 64'(err_stray), 64'd0);
        tick();

        // Round-robin burst 1: pointer starts at A
        do_issue(5'd3);
        do_issue(5'd4);
        a_valid = 1'b1; a_wa = 5'd3; a_wd = 32'h33;
        b_valid = 1'b1; b_wa = 5'd4; b_wd = 32'h44;
        @(negedge clk);
        chk("rr1_a_first", 64'(a_ready), 64'd1);
        chk("rr1_b_wait", 64'(b_ready), 64'd0);
        push(5'd3, 32'h33);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("rr1_b_second", 64'(b_ready), 64'd1);
        chk("rr1_we3_a", 64'(we3), 64'd1);
        push(5'd4, 32'h44);
        tick();
        b_valid = 1'b0;
        chk("rr1_we3_b", 64'(we3), 64'd1);

        // Round-robin burst 2: pointer now at B
        do_issue(5'd3);
        do_issue(5'd4);
        a_valid = 1'b1; a_wa = 5'd3; a_wd = 32'h333;
        b_valid = 1'b1; b_wa = 5'd4; b_wd = 32'h444;
        @(negedge clk);
        chk("rr2_b_first", 64'(b_ready), 64'd1);
        chk("rr2_a_wait", 64'(a_ready), 64'd0);
        push(5'd4, 32'h444);
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk("rr2_a_second", 64'(a_ready), 64'd1);
        chk("rr2_we3_b", 64'(we3), 64'd1);
        push(5'd3, 32'h333);
        tick();
        a_valid = 1'b0;
        chk("rr2_we3_a", 64'(we3), 64'd1);
        tick();
        chk("rr_no_err", 64'(err_stray), 64'd0);

        // Hazard stalls on r7
        do_issue(5'd7);
        issue_valid = 1'b1; issue_ra1 = 5'd7; issue_ra2 = '0; issue_wa = '0;
        @(negedge clk);
        chk("raw_ra1_stall", 64'(issue_ready), 64'd0);
        issue_ra1 = '0; issue_ra2 = 5'd7;
        #1 chk("raw_ra2_stall", 64'(issue_ready), 64'd0);
        issue_ra2 = '0; issue_wa = 5'd7;
        #1 chk("waw_stall", 64'(issue_ready), 64'd0);
        issue_wa = '0;
        #1 chk("r0_no_stall", 64'(issue_ready), 64'd1);
        issue_ra1 = 5'd7;
        a_valid = 1'b1; a_wa = 5'd7; a_wd = 32'h77;
        #1 chk("a_ready_r7", 64'(a_ready), 64'd1);
        push(5'd7, 32'h77);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("no_bypass_stall", 64'(issue_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("stall_released", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0; issue_ra1 = '0;

        // Stray write to non-busy r12
        chk("err_before_stray", 64'(err_stray), 64'd0);
        single_write(1'b1, 5'd12, 32'hC0FFEE);
        chk("err_stray_set", 64'(err_stray), 64'd1);
        tick();

        // Set/clear collision on r9 (write is itself stray, flag stays)
        single_write(1'b1, 5'd9, 32'h99);
        issue_valid = 1'b1; issue_wa = 5'd9;
        @(negedge clk);
        chk("issue_r9_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0; issue_wa = '0;
        chk("collision_set_wins", 64'(busy[9]), 64'd1);
        chk("err_sticky", 64'(err_stray), 64'd1);
        single_write(1'b0, 5'd9, 32'h999);
        tick();
        chk("busy9_cleared", 64'(busy[9]), 64'd0);

        // Contended grant moves pointer to B, then reset mid-write
        do_issue(5'd20);
        do_issue(5'd21);
        a_valid = 1'b1; a_wa = 5'd20; a_wd = 32'hABCD;
        b_valid = 1'b1; b_wa = 5'd21; b_wd = 32'h2121;
        @(negedge clk);
        chk("pre_rst_a_grant", 64'(a_ready), 64'd1);
        push(5'd20, 32'hABCD);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("pre_rst_we3", 64'(we3), 64'd1);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_we3", 64'(we3), 64'd0);
        chk("async_rst_wd3", 64'(wd3), 64'd0);
        chk("async_rst_wa3", 64'(wa3), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_err", 64'(err_stray), 64'd0);
        tick();
        reset = 1'b0;

        // Pointer back at A after reset
        do_issue(5'd3);
        do_issue(5'd4);
        a_valid = 1'b1; a_wa = 5'd3; a_wd = 32'h5A5A;
        b_valid = 1'b1; b_wa = 5'd4; b_wd = 32'hA5A5;
        @(negedge clk);
        chk("post_rst_a_first", 64'(a_ready), 64'd1);
        chk("post_rst_b_wait", 64'(b_ready), 64'd0);
        push(5'd3, 32'h5A5A);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_b_second", 64'(b_ready), 64'd1);
        push(5'd4, 32'hA5A5);
        tick();
        b_valid = 1'b0;
        repeat (2) tick();
        chk("final_busy", 64'(busy), 64'd0);
        chk("final_err", 64'(err_stray), 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
